// File: rtl/pc_seq_pkg.sv
// Shared types and default widths for the pc_sequencer program store / PC block.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2
   } pc_state_e;

   localparam int ADDR_W_DEF = 6;
   localparam int INST_W_DEF = 23;
   localparam int DATA_W_DEF = 16;

endpackage

// File: rtl/pc_prog_mem.sv
// Program store: DEPTH x INST_W RAM with one write port and a registered,
// enable-gated read port whose output register resets to zero.
module pc_prog_mem
   import pc_seq_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int INST_W = INST_W_DEF,
   parameter int DEPTH  = int'(32'd1 << ADDR_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [INST_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [INST_W-1:0] rdata
);

   logic [INST_W-1:0] mem_r [DEPTH];
   logic [INST_W-1:0] rdata_r;

   // Storage array write; contents are deliberately left untouched by reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Read register holds its value whenever re is low
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata_r <= {INST_W{1'b0}};
      end else if (re) begin
         rdata_r <= mem_r[raddr];
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/pc_sequencer.sv
// Program store plus PC sequencer with IDLE/LOAD/RUN control and registered fetch.
// Optional return stack (call/ret/stack_err) is built when PC_STACK_EN is defined.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int INST_W = INST_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = int'(32'd1 << ADDR_W)
`ifdef PC_STACK_EN
   ,
   parameter int STACK_DEPTH = 4
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              write,
   input  logic [INST_W-1:0] program_in,
   input  logic              start,
   input  logic              inc_pc,
   input  logic              branch,
   input  logic [DATA_W-1:0] bus,
   input  logic              halt,
`ifdef PC_STACK_EN
   input  logic              call,
   input  logic              ret,
   output logic              stack_err,
`endif
   output logic [ADDR_W-1:0] address,
   output logic [INST_W-1:0] code,
   output logic              code_valid,
   output logic [ADDR_W:0]   load_count,
   output logic              load_full,
   output logic              running
);

   localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_C    = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

   pc_state_e         state_r, state_nxt_s;
   logic [ADDR_W-1:0] address_r, addr_nxt_s, addr_inc_s, target_s;
   logic [ADDR_W:0]   load_count_r, load_cnt_nxt_s;
   logic              code_valid_r, load_full_r, running_r;
   logic              mem_we_s, fetch_s;

`ifdef PC_STACK_EN
   localparam int              SP_W    = $clog2(STACK_DEPTH + 1);
   localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
   localparam logic [SP_W-1:0] SP_ZERO = {SP_W{1'b0}};
   localparam logic [SP_W-1:0] SP_ONE  = {{(SP_W-1){1'b0}}, 1'b1};

   logic [ADDR_W-1:0] stack_r [2**SP_W];
   logic [SP_W-1:0]   sp_r, sp_nxt_s;
   logic              push_s, err_set_s, stack_err_r;
`endif

   // Only the low ADDR_W bus bits address the store; the rest are don't-care
   generate
      if (DATA_W > ADDR_W) begin : g_bus_hi
         logic unused_bus_hi_s;
         assign unused_bus_hi_s = ^bus[DATA_W-1:ADDR_W];
      end
   endgenerate

   // Wrapped increment and range-checked branch target
   always_comb begin
      if (address_r == LAST_C) begin
         addr_inc_s = ADDR_ZERO;
      end else begin
         addr_inc_s = address_r + ADDR_ONE;
      end
      if ({1'b0, bus[ADDR_W-1:0]} < DEPTH_C) begin
         target_s = bus[ADDR_W-1:0];
      end else begin
         target_s = ADDR_ZERO;
      end
   end

   // Next-state, next-PC and load-pointer decode
   always_comb begin
      state_nxt_s    = state_r;
      addr_nxt_s     = address_r;
      load_cnt_nxt_s = load_count_r;
      mem_we_s       = 1'b0;
`ifdef PC_STACK_EN
      sp_nxt_s       = sp_r;
      push_s         = 1'b0;
      err_set_s      = 1'b0;
`endif
      case (state_r)
         IDLE, LOAD: begin
            if (write) begin
               state_nxt_s = LOAD;
               // Saturate: once the store is full further words are dropped
               if (load_count_r != DEPTH_C) begin
                  mem_we_s       = 1'b1;
                  load_cnt_nxt_s = load_count_r + CNT_ONE;
               end else begin
                  mem_we_s       = 1'b0;
                  load_cnt_nxt_s = load_count_r;
               end
            end else if (start && (state_r == IDLE)) begin
               state_nxt_s = RUN;
               addr_nxt_s  = ADDR_ZERO;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         RUN: begin
            if (halt) begin
               state_nxt_s = IDLE;
            end else if (start) begin
               addr_nxt_s = ADDR_ZERO;
`ifdef PC_STACK_EN
            end else if (call) begin
               if (sp_r == SP_FULL) begin
                  addr_nxt_s = addr_inc_s;
                  err_set_s  = 1'b1;
               end else begin
                  push_s     = 1'b1;
                  sp_nxt_s   = sp_r + SP_ONE;
                  addr_nxt_s = target_s;
               end
            end else if (ret) begin
               if (sp_r == SP_ZERO) begin
                  addr_nxt_s = addr_inc_s;
                  err_set_s  = 1'b1;
               end else begin
                  sp_nxt_s   = sp_r - SP_ONE;
                  addr_nxt_s = stack_r[sp_r - SP_ONE];
               end
`endif
            end else if (branch) begin
               addr_nxt_s = target_s;
            end else if (inc_pc) begin
               addr_nxt_s = addr_inc_s;
            end else begin
               addr_nxt_s = address_r;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            addr_nxt_s  = ADDR_ZERO;
         end
      endcase
   end

   // Fetch from the next PC so code lines up with address on the same cycle
   assign fetch_s = (state_nxt_s == RUN);

   pc_prog_mem #(
      .ADDR_W (ADDR_W),
      .INST_W (INST_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (mem_we_s),
      .waddr (load_count_r[ADDR_W-1:0]),
      .wdata (program_in),
      .re    (fetch_s),
      .raddr (addr_nxt_s),
      .rdata (code)
   );

   // Control and status registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         address_r    <= ADDR_ZERO;
         load_count_r <= {(ADDR_W+1){1'b0}};
         code_valid_r <= 1'b0;
         load_full_r  <= 1'b0;
         running_r    <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         address_r    <= addr_nxt_s;
         load_count_r <= load_cnt_nxt_s;
         code_valid_r <= (state_r == RUN) && (state_nxt_s == RUN);
         load_full_r  <= (load_cnt_nxt_s == DEPTH_C);
         running_r    <= (state_nxt_s == RUN);
      end
   end

`ifdef PC_STACK_EN
   // Return-stack pointer and sticky error flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sp_r        <= SP_ZERO;
         stack_err_r <= 1'b0;
      end else begin
         sp_r        <= sp_nxt_s;
         stack_err_r <= stack_err_r | err_set_s;
      end
   end

   // Return-address storage
   always_ff @(posedge clk) begin
      if (push_s) begin
         stack_r[sp_r] <= addr_inc_s;
      end
   end

   assign stack_err = stack_err_r;
`endif

   assign address    = address_r;
   assign code_valid = code_valid_r;
   assign load_count = load_count_r;
   assign load_full  = load_full_r;
   assign running    = running_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; PC_STACK_EN also enables the return-stack scenario.
module tb_pc_sequencer;

   localparam int ADDR_W = 6;
   localparam int INST_W = 23;
   localparam int DATA_W = 16;

   logic              clk = 1'b0;
   logic              rst_n, write, start, inc_pc, branch, halt;
   logic [INST_W-1:0] program_in;
   logic [DATA_W-1:0] bus;
   logic [ADDR_W-1:0] address;
   logic [INST_W-1:0] code;
   logic              code_valid, load_full, running;
   logic [ADDR_W:0]   load_count;
`ifdef PC_STACK_EN
   logic              call, ret, stack_err;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pc_sequencer #(
      .ADDR_W (ADDR_W),
      .INST_W (INST_W),
      .DATA_W (DATA_W)
`ifdef PC_STACK_EN
      , .STACK_DEPTH (2)
`endif
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .write      (write),
      .program_in (program_in),
      .start      (start),
      .inc_pc     (inc_pc),
      .branch     (branch),
      .bus        (bus),
      .halt       (halt),
`ifdef PC_STACK_EN
      .call       (call),
      .ret        (ret),
      .stack_err  (stack_err),
`endif
      .address    (address),
      .code       (code),
      .code_valid (code_valid),
      .load_count (load_count),
      .load_full  (load_full),
      .running    (running)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; write = 1'b0; start = 1'b0; inc_pc = 1'b0; branch = 1'b0;
      halt = 1'b0; program_in = 23'd0; bus = 16'd0;
`ifdef PC_STACK_EN
      call = 1'b0; ret = 1'b0;
`endif
      step(); step();
      checks++; if (address !== 6'd0) begin errors++; $display("FAIL rst_addr got=%0h exp=0", address); end
      checks++; if (code !== 23'd0) begin errors++; $display("FAIL rst_code got=%0h exp=0", code); end
      checks++; if ({code_valid, load_full, running} !== 3'b000) begin errors++; $display("FAIL rst_flags got=%b exp=000", {code_valid, load_full, running}); end
      checks++; if (load_count !== 7'd0) begin errors++; $display("FAIL rst_cnt got=%0d exp=0", load_count); end
      rst_n = 1'b1;
   endtask

   task automatic test_load();
      for (int k = 1; k <= 4; k++) begin
         write = 1'b1; program_in = 23'(k);
         start = (k == 4) ? 1'b1 : 1'b0;
         step();
      end
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL write_beats_start got=%b exp=0", running); end
      checks++; if (load_count !== 7'd4) begin errors++; $display("FAIL load_cnt4 got=%0d exp=4", load_count); end
      checks++; if (load_full !== 1'b0) begin errors++; $display("FAIL load_full4 got=%b exp=0", load_full); end
      write = 1'b0; start = 1'b0;
      step();
   endtask

   task automatic test_start();
      start = 1'b1;
      step();
      start = 1'b0;
      checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_run got=%b exp=1", running); end
      checks++; if (address !== 6'd0) begin errors++; $display("FAIL start_addr got=%0h exp=0", address); end
      checks++; if (code !== 23'h000001) begin errors++; $display("FAIL start_code got=%0h exp=1", code); end
      checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL start_cv0 got=%b exp=0", code_valid); end
      step();
      checks++; if (code_valid !== 1'b1) begin errors++; $display("FAIL start_cv1 got=%b exp=1", code_valid); end
      checks++; if (code !== 23'h000001) begin errors++; $display("FAIL start_code2 got=%0h exp=1", code); end
   endtask

   task automatic test_inc_branch();
      inc_pc = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         step();
         checks++; if (address !== 6'(i)) begin errors++; $display("FAIL inc_addr%0d got=%0h exp=%0h", i, address, i); end
         checks++; if (code !== 23'(i + 1)) begin errors++; $display("FAIL inc_code%0d got=%0h exp=%0h", i, code, i + 1); end
      end
      inc_pc = 1'b0; branch = 1'b1; bus = 16'h0001;
      step();
      branch = 1'b0;
      checks++; if (address !== 6'd1) begin errors++; $display("FAIL br_addr got=%0h exp=1", address); end
      checks++; if (code !== 23'h000002) begin errors++; $display("FAIL br_code got=%0h exp=2", code); end
      write = 1'b1; program_in = 23'h000055;
      step();
      write = 1'b0;
      checks++; if (load_count !== 7'd4) begin errors++; $display("FAIL run_write_cnt got=%0d exp=4", load_count); end
      checks++; if (address !== 6'd1) begin errors++; $display("FAIL run_write_addr got=%0h exp=1", address); end
      start = 1'b1;
      step();
      start = 1'b0;
      checks++; if ({address, code_valid} !== {6'd0, 1'b1}) begin errors++; $display("FAIL restart got=%0h/%b exp=0/1", address, code_valid); end
      checks++; if (code !== 23'h000001) begin errors++; $display("FAIL restart_code got=%0h exp=1", code); end
      halt = 1'b1;
      step();
      halt = 1'b0;
      checks++; if ({running, code_valid} !== 2'b00) begin errors++; $display("FAIL halt_flags got=%b exp=00", {running, code_valid}); end
   endtask

   task automatic test_load_full();
      for (int k = 0; k < 62; k++) begin
         write = 1'b1; program_in = 23'(32'h100 + k);
         step();
         if (k == 58) begin
            checks++; if ({load_count, load_full} !== {7'd63, 1'b0}) begin errors++; $display("FAIL near_full got=%0d/%b exp=63/0", load_count, load_full); end
         end
      end
      write = 1'b0;
      checks++; if (load_count !== 7'd64) begin errors++; $display("FAIL full_cnt got=%0d exp=64", load_count); end
      checks++; if (load_full !== 1'b1) begin errors++; $display("FAIL full_flag got=%b exp=1", load_full); end
      step();
      start = 1'b1;
      step();
      start = 1'b0;
      checks++; if (code !== 23'h000001) begin errors++; $display("FAIL mem0_kept got=%0h exp=1", code); end
      branch = 1'b1; bus = 16'h003F;
      step();
      branch = 1'b0;
      checks++; if ({address, code} !== {6'd63, 23'h00013B}) begin errors++; $display("FAIL br_last got=%0h/%0h exp=3f/13b", address, code); end
      inc_pc = 1'b1;
      step();
      checks++; if ({address, code} !== {6'd0, 23'h000001}) begin errors++; $display("FAIL wrap got=%0h/%0h exp=0/1", address, code); end
      step();
      halt = 1'b1;
      step();
      halt = 1'b0; inc_pc = 1'b0;
      checks++; if (address !== 6'd1) begin errors++; $display("FAIL halt_hold got=%0h exp=1", address); end
      checks++; if ({running, code_valid} !== 2'b00) begin errors++; $display("FAIL halt_inc_flags got=%b exp=00", {running, code_valid}); end
      checks++; if (code !== 23'h000002) begin errors++; $display("FAIL halt_code_held got=%0h exp=2", code); end
   endtask

   task automatic test_reset_mid_run();
      start = 1'b1;
      step();
      start = 1'b0; branch = 1'b1; bus = 16'h0005;
      step();
      branch = 1'b0;
      checks++; if ({address, code} !== {6'd5, 23'h000101}) begin errors++; $display("FAIL pre_rst got=%0h/%0h exp=5/101", address, code); end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      checks++; if ({address, running, code_valid} !== {6'd0, 2'b00}) begin errors++; $display("FAIL midrst got=%0h/%b/%b exp=0/0/0", address, running, code_valid); end
      checks++; if ({load_count, load_full} !== {7'd0, 1'b0}) begin errors++; $display("FAIL midrst_cnt got=%0d/%b exp=0/0", load_count, load_full); end
      write = 1'b1; program_in = 23'h0ABCDE;
      step();
      write = 1'b0;
      step();
      checks++; if (load_count !== 7'd1) begin errors++; $display("FAIL reload_cnt got=%0d exp=1", load_count); end
      start = 1'b1;
      step();
      start = 1'b0;
      checks++; if (code !== 23'h0ABCDE) begin errors++; $display("FAIL reload_mem0 got=%0h exp=abcde", code); end
   endtask

`ifdef PC_STACK_EN
   task automatic test_stack();
      branch = 1'b1; bus = 16'd3;
      step();
      branch = 1'b0; call = 1'b1; bus = 16'd10;
      step();
      call = 1'b0;
      checks++; if (address !== 6'd10) begin errors++; $display("FAIL call_addr got=%0d exp=10", address); end
      ret = 1'b1;
      step();
      ret = 1'b0;
      checks++; if ({address, stack_err} !== {6'd4, 1'b0}) begin errors++; $display("FAIL ret_addr got=%0d/%b exp=4/0", address, stack_err); end
      call = 1'b1; bus = 16'd20; step();
      bus = 16'd30; step();
      bus = 16'd40; step();
      call = 1'b0;
      checks++; if ({address, stack_err} !== {6'd31, 1'b1}) begin errors++; $display("FAIL call_full got=%0d/%b exp=31/1", address, stack_err); end
      ret = 1'b1; step();
      checks++; if (address !== 6'd21) begin errors++; $display("FAIL ret1 got=%0d exp=21", address); end
      step();
      checks++; if (address !== 6'd5) begin errors++; $display("FAIL ret2 got=%0d exp=5", address); end
      step();
      ret = 1'b0;
      checks++; if ({address, stack_err} !== {6'd6, 1'b1}) begin errors++; $display("FAIL ret_empty got=%0d/%b exp=6/1", address, stack_err); end
   endtask
`endif

   initial begin
      test_reset();
      test_load();
      test_start();
      test_inc_branch();
      test_load_full();
      test_reset_mid_run();
`ifdef PC_STACK_EN
      test_stack();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
